// File: rtl/bcd_ctr_multi_if.sv
// bcd_ctr_multi_if: control/data bundle for bcd_ctr_multi (master drives controls, slave is the counter)
// The Err signal exists only when BCD_CTR_LOADCHK_EN is defined.
interface bcd_ctr_multi_if #(
    parameter int DIGITS = 4
);
    logic                  En;
    logic                  Up;
    logic                  Load;
    logic [4*DIGITS-1:0]   D;
    logic [4*DIGITS-1:0]   BCD;
    logic                  TC;
`ifdef BCD_CTR_LOADCHK_EN
    logic                  Err;
`endif

    modport master (
        output En, Up, Load, D,
        input  BCD, TC
`ifdef BCD_CTR_LOADCHK_EN
        , input Err
`endif
    );

    modport slave (
        input  En, Up, Load, D,
        output BCD, TC
`ifdef BCD_CTR_LOADCHK_EN
        , output Err
`endif
    );
endinterface

// File: rtl/bcd_ctr_multi.sv
// bcd_ctr_multi: multi-digit up/down BCD counter with parallel load, terminal count and optional saturation
// Defining BCD_CTR_LOADCHK_EN rejects loads containing non-BCD digits and raises a sticky Err.
module bcd_ctr_multi #(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input logic            clk,
    input logic            Clear,
    bcd_ctr_multi_if.slave bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] bcd_q, bcd_d, inc, dec;
    logic [3:0]   dg;
    logic         cy, bw, all9, all0, tc, step, load_ok;
`ifdef BCD_CTR_LOADCHK_EN
    logic         bad, err_q, err_d;
`endif

    // Ripple carry/borrow across digits; non-BCD digits recover to 0 (carrying) or 9 (not borrowing)
    always_comb begin
        inc  = bcd_q;
        dec  = bcd_q;
        dg   = '0;
        cy   = 1'b1;
        bw   = 1'b1;
        all9 = 1'b1;
        all0 = 1'b1;
`ifdef BCD_CTR_LOADCHK_EN
        bad  = 1'b0;
`endif
        for (int i = 0; i < DIGITS; i++) begin
            dg = bcd_q[4*i +: 4];
            if (cy) inc[4*i +: 4] = (dg >= 4'd9) ? 4'd0 : dg + 4'd1;
            if (bw) dec[4*i +: 4] = (dg == 4'd0 || dg > 4'd9) ? 4'd9 : dg - 4'd1;
            cy   = cy & (dg >= 4'd9);
            bw   = bw & (dg == 4'd0);
            all9 = all9 & (dg == 4'd9);
            all0 = all0 & (dg == 4'd0);
`ifdef BCD_CTR_LOADCHK_EN
            bad  = bad | (bus.D[4*i +: 4] > 4'd9);
`endif
        end
    end

    assign tc   = bus.En & ~bus.Load & (bus.Up ? all9 : all0);
    assign step = bus.En & ~(SATURATE & tc);
`ifdef BCD_CTR_LOADCHK_EN
    assign load_ok = ~bad;
    assign err_d   = err_q | (bus.Load & bad);
`else
    assign load_ok = 1'b1;
`endif

    always_comb begin
        bcd_d = bus.Load ? (load_ok ? bus.D : bcd_q) : step ? (bus.Up ? inc : dec) : bcd_q;
    end

    always_ff @(posedge clk) begin
        if (Clear) begin
            bcd_q <= '0;
`ifdef BCD_CTR_LOADCHK_EN
            err_q <= 1'b0;
`endif
        end else begin
            bcd_q <= bcd_d;
`ifdef BCD_CTR_LOADCHK_EN
            err_q <= err_d;
`endif
        end
    end

    assign bus.BCD = bcd_q;
    assign bus.TC  = tc;
`ifdef BCD_CTR_LOADCHK_EN
    assign bus.Err = err_q;
`endif
endmodule

// File: tb/tb_bcd_ctr_multi.sv
// tb_bcd_ctr_multi: directed and randomized checks of a 2-digit wrapping and a 3-digit saturating counter
// Works with and without BCD_CTR_LOADCHK_EN.
module tb_bcd_ctr_multi;
    logic clk = 1'b0;
    logic clr2 = 1'b0;
    logic clr3 = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bcd_ctr_multi_if #(.DIGITS(2)) if2 ();
    bcd_ctr_multi_if #(.DIGITS(3)) if3 ();

    bcd_ctr_multi #(.DIGITS(2), .SATURATE(1'b0)) u2 (.clk(clk), .Clear(clr2), .bus(if2));
    bcd_ctr_multi #(.DIGITS(3), .SATURATE(1'b1)) u3 (.clk(clk), .Clear(clr3), .bus(if3));

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input logic c, input logic l, input logic e, input logic u, input logic [7:0] d);
        clr2 = c; if2.Load = l; if2.En = e; if2.Up = u; if2.D = d;
    endtask

    task automatic drv3(input logic c, input logic l, input logic e, input logic u, input logic [11:0] d);
        clr3 = c; if3.Load = l; if3.En = e; if3.Up = u; if3.D = d;
    endtask

    task automatic test_reset;
        drv2(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drv3(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        tests++; if (if2.BCD !== 8'h00) begin fails++; $display("FAIL reset2_bcd got %h want 00", if2.BCD); end
        tests++; if (if3.BCD !== 12'h000) begin fails++; $display("FAIL reset3_bcd got %h want 000", if3.BCD); end
        tests++; if (if2.TC !== 1'b0) begin fails++; $display("FAIL reset2_tc got %b want 0", if2.TC); end
`ifdef BCD_CTR_LOADCHK_EN
        tests++; if (if2.Err !== 1'b0) begin fails++; $display("FAIL reset2_err got %b want 0", if2.Err); end
        tests++; if (if3.Err !== 1'b0) begin fails++; $display("FAIL reset3_err got %b want 0", if3.Err); end
`endif
    endtask

    task automatic test_up_wrap;
        logic [31:0] e;
        drv2(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 100; k++) begin
            #1;
            tests++; if (if2.TC !== (k == 99)) begin fails++; $display("FAIL up_tc k=%0d got %b want %b", k, if2.TC, (k == 99)); end
            tick();
            e = to_bcd((k + 1) % 100);
            tests++; if (if2.BCD !== e[7:0]) begin fails++; $display("FAIL up_bcd k=%0d got %h want %h", k, if2.BCD, e[7:0]); end
        end
    endtask

    task automatic test_down_wrap;
        logic [31:0] e;
        int v;
        drv2(1'b0, 1'b1, 1'b0, 1'b0, 8'h10);
        tick();
        tests++; if (if2.BCD !== 8'h10) begin fails++; $display("FAIL down_load got %h want 10", if2.BCD); end
        drv2(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        v = 10;
        for (int k = 0; k < 11; k++) begin
            #1;
            tests++; if (if2.TC !== (v == 0)) begin fails++; $display("FAIL down_tc v=%0d got %b want %b", v, if2.TC, (v == 0)); end
            tick();
            v = (v + 99) % 100;
            e = to_bcd(v);
            tests++; if (if2.BCD !== e[7:0]) begin fails++; $display("FAIL down_bcd got %h want %h", if2.BCD, e[7:0]); end
        end
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_saturate;
        drv3(1'b0, 1'b1, 1'b0, 1'b1, 12'h998);
        tick();
        drv3(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++; if (if3.TC !== (k > 0)) begin fails++; $display("FAIL sat_tc k=%0d got %b want %b", k, if3.TC, (k > 0)); end
            tick();
            tests++; if (if3.BCD !== 12'h999) begin fails++; $display("FAIL sat_hold k=%0d got %h want 999", k, if3.BCD); end
        end
        drv3(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        #1;
        tests++; if (if3.TC !== 1'b0) begin fails++; $display("FAIL sat_rev_tc got %b want 0", if3.TC); end
        tick();
        tests++; if (if3.BCD !== 12'h998) begin fails++; $display("FAIL sat_reverse got %h want 998", if3.BCD); end
    endtask

    task automatic test_clear_load;
        drv3(1'b0, 1'b1, 1'b0, 1'b0, 12'h457);
        tick();
        tests++; if (if3.BCD !== 12'h457) begin fails++; $display("FAIL cl_load got %h want 457", if3.BCD); end
        drv3(1'b1, 1'b1, 1'b1, 1'b1, 12'h321);
        tick();
        tests++; if (if3.BCD !== 12'h000) begin fails++; $display("FAIL cl_clear got %h want 000", if3.BCD); end
        drv3(1'b0, 1'b1, 1'b1, 1'b1, 12'h123);
        #1;
        tests++; if (if3.TC !== 1'b0) begin fails++; $display("FAIL cl_tc_load got %b want 0", if3.TC); end
        tick();
        tests++; if (if3.BCD !== 12'h123) begin fails++; $display("FAIL cl_load_nocount got %h want 123", if3.BCD); end
        drv3(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        tick();
        tests++; if (if3.BCD !== 12'h123) begin fails++; $display("FAIL cl_hold got %h want 123", if3.BCD); end
    endtask

`ifdef BCD_CTR_LOADCHK_EN
    task automatic test_loadchk;
        drv2(1'b0, 1'b1, 1'b0, 1'b0, 8'h17);
        tick();
        tests++; if (if2.BCD !== 8'h17 || if2.Err !== 1'b0) begin fails++; $display("FAIL chk_legal got %h/%b want 17/0", if2.BCD, if2.Err); end
        drv2(1'b0, 1'b1, 1'b1, 1'b1, 8'h3A);
        tick();
        tests++; if (if2.BCD !== 8'h17 || if2.Err !== 1'b1) begin fails++; $display("FAIL chk_reject got %h/%b want 17/1", if2.BCD, if2.Err); end
        drv2(1'b0, 1'b1, 1'b0, 1'b0, 8'h42);
        tick();
        tests++; if (if2.BCD !== 8'h42 || if2.Err !== 1'b1) begin fails++; $display("FAIL chk_sticky got %h/%b want 42/1", if2.BCD, if2.Err); end
        drv2(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tests++; if (if2.BCD !== 8'h00 || if2.Err !== 1'b0) begin fails++; $display("FAIL chk_clear got %h/%b want 00/0", if2.BCD, if2.Err); end
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask
`else
    task automatic test_nonbcd;
        drv2(1'b0, 1'b1, 1'b0, 1'b0, 8'h0C);
        tick();
        tests++; if (if2.BCD !== 8'h0C) begin fails++; $display("FAIL nb_load got %h want 0c", if2.BCD); end
        drv2(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tick();
        tests++; if (if2.BCD !== 8'h10) begin fails++; $display("FAIL nb_up got %h want 10", if2.BCD); end
        drv2(1'b0, 1'b1, 1'b0, 1'b0, 8'h0C);
        tick();
        drv2(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        tests++; if (if2.BCD !== 8'h09) begin fails++; $display("FAIL nb_down got %h want 09", if2.BCD); end
        drv3(1'b0, 1'b1, 1'b0, 1'b0, 12'hA00);
        tick();
        drv3(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        tick();
        tests++; if (if3.BCD !== 12'h999) begin fails++; $display("FAIL nb_down3 got %h want 999", if3.BCD); end
        drv3(1'b0, 1'b1, 1'b0, 1'b0, 12'h9C9);
        tick();
        drv3(1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        #1;
        tests++; if (if3.TC !== 1'b0) begin fails++; $display("FAIL nb_tc3 got %b want 0", if3.TC); end
        tick();
        tests++; if (if3.BCD !== 12'h000) begin fails++; $display("FAIL nb_up3 got %h want 000", if3.BCD); end
        drv2(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drv3(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    endtask
`endif

    // Reference model keeps each count as a plain decimal integer
    task automatic test_random;
        int m2, m3, v2, v3;
        logic c2, l2, e2, u2r, c3, l3, e3, u3r, t2, t3;
        logic [31:0] b;
        drv2(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drv3(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
        tick();
        m2 = 0;
        m3 = 0;
        for (int k = 0; k < 400; k++) begin
            c2 = ($urandom % 32) == 0; l2 = ($urandom % 6) == 0; e2 = ($urandom % 4) != 0; u2r = 1'($urandom % 2);
            c3 = ($urandom % 32) == 0; l3 = ($urandom % 6) == 0; e3 = ($urandom % 4) != 0; u3r = 1'($urandom % 2);
            v2 = int'($urandom % 100);
            v3 = (($urandom % 4) == 0) ? 999 * int'($urandom % 2) : int'($urandom % 1000);
            b = to_bcd(v2);
            drv2(c2, l2, e2, u2r, b[7:0]);
            b = to_bcd(v3);
            drv3(c3, l3, e3, u3r, b[11:0]);
            t2 = e2 & ~l2 & (u2r ? (m2 == 99) : (m2 == 0));
            t3 = e3 & ~l3 & (u3r ? (m3 == 999) : (m3 == 0));
            #1;
            tests++; if (if2.TC !== t2) begin fails++; $display("FAIL rnd_tc2 k=%0d got %b want %b", k, if2.TC, t2); end
            tests++; if (if3.TC !== t3) begin fails++; $display("FAIL rnd_tc3 k=%0d got %b want %b", k, if3.TC, t3); end
            if (c2) m2 = 0;
            else if (l2) m2 = v2;
            else if (e2) m2 = u2r ? (m2 + 1) % 100 : (m2 + 99) % 100;
            if (c3) m3 = 0;
            else if (l3) m3 = v3;
            else if (e3 && !t3) m3 = u3r ? m3 + 1 : m3 - 1;
            tick();
            b = to_bcd(m2);
            tests++; if (if2.BCD !== b[7:0]) begin fails++; $display("FAIL rnd_bcd2 k=%0d got %h want %h", k, if2.BCD, b[7:0]); end
            b = to_bcd(m3);
            tests++; if (if3.BCD !== b[11:0]) begin fails++; $display("FAIL rnd_bcd3 k=%0d got %h want %h", k, if3.BCD, b[11:0]); end
`ifdef BCD_CTR_LOADCHK_EN
            tests++; if (if2.Err !== 1'b0 || if3.Err !== 1'b0) begin fails++; $display("FAIL rnd_err k=%0d got %b%b want 00", k, if2.Err, if3.Err); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_clear_load();
`ifdef BCD_CTR_LOADCHK_EN
        test_loadchk();
`else
        test_nonbcd();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bcd_ctr_multi.md
Name: bcd_ctr_multi

Overview:
- Parametrised multi-digit synchronous BCD counter; successor to the single-digit decade counter.
- Adds digit count, up/down direction, parallel load, a terminal-count output for cascading, and an optional saturate mode.
- Used by the lab display/timer datapaths, e.g. stopwatch and score counters, that drive 7-segment decoders digit by digit.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); counter width is 4*DIGITS bits.
- SATURATE, 0, 0 = wrap at terminal count; 1 = hold at terminal count.

Ports:
- clk  input  1  rising-edge clock.
- Clear  input  1  synchronous active-high reset. Sampled only on a clk rising edge.
- En  input  1  count enable; one step per clk while high.
- Up  input  1  direction: 1 = increment, 0 = decrement.
- Load  input  1  synchronous parallel load of D.
- D  input  4*DIGITS  load value; digit i is D[4i+3:4i], with digit 0 as the LSD.
- BCD  output  4*DIGITS  registered count, same digit packing as D.
- TC  output  1  terminal count, combinational from the registered state and inputs.
- Err  output  1  sticky illegal-load flag. Present only with BCD_CTR_LOADCHK_EN.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high.
- Priority at each rising edge: Clear > Load > En.
- Clear: BCD <= 0, and Err <= 0 when present. Clear has no asynchronous effect. If Clear is asserted mid-count, the count is zero after that edge.
- Load=1: BCD <= D on the next edge, regardless of En and Up. No count step occurs in that cycle.
- En=0 and Load=0: BCD holds.
- Increment rule, per digit:
  - Digit 0 always receives carry-in = 1.
  - Digit i receives carry-in when all lower digits are 9.
  - A digit with carry-in: if it is 9, it becomes 0 and carries; otherwise it becomes digit+1.
  - A digit with a non-BCD value (10..15) and carry-in becomes 0 and carries.
- Decrement rule, per digit:
  - Borrow-in to digit i when all lower digits are 0; digit 0 always borrows.
  - A digit with borrow-in: if it is 0, it becomes 9 and borrows; otherwise it becomes digit-1.
  - A digit with a non-BCD value (10..15) and borrow-in becomes 9 with no further borrow.
- TC = En & ~Load & ((Up & all digits 9) | (~Up & all digits 0)).
  - TC is asserted in the cycle before the wrap edge and is suitable as the En of a cascaded stage.
  - Clear does not gate TC.
- Terminal edge with SATURATE=0: all-9s up-count goes to all-0s; all-0s down-count goes to all-9s.
- Terminal edge with SATURATE=1: BCD holds at all-9s (up) or all-0s (down). TC stays high while En is held.
  - Reversing Up at the terminal count resumes counting normally.
- Changes of Up take effect on the same edge with no extra latency.
- Latency: every BCD update is visible one clk after the sampled control.

Optional Feature:
- Macro: BCD_CTR_LOADCHK_EN.
- Defined:
  - Load with any digit of D > 9 is rejected: BCD holds and Err <= 1.
  - Err stays high until Clear.
  - A legal load is accepted normally and does not clear Err.
- Undefined:
  - The Err port does not exist.
  - D is loaded verbatim, and non-BCD digits follow the increment/decrement recovery rules above.

Test Plan:
- DIGITS=2, Clear 1 cycle, then En=1 Up=1 for 100 cycles -> BCD steps 00..99. TC=1 only at 99. The next edge gives 00 (SATURATE=0).
- DIGITS=2, Load D=8'h10 then En=1 Up=0 -> 09, 08, ..., 00. TC=1 at 00. The next edge gives 99.
- DIGITS=3 SATURATE=1, Load 12'h998, En=1 Up=1 for 4 cycles -> 999, 999, 999 holding with TC=1. Set Up=0 -> 998.
- Assert Clear and Load together with En=1 at BCD=0x0457 -> BCD=0000 next edge. Load=1 En=1 Up=1 D=0x0123 -> 0123 (no count).
- BCD_CTR_LOADCHK_EN: Load D=8'h3A -> BCD unchanged, Err=1. Load 8'h42 -> BCD=42, Err=1. Clear -> Err=0.
- Without the macro: Load D=8'h0C, En=1 Up=1 -> 10 (digit 0 wraps with carry). Second run: Load 8'h0C, Up=0 -> 09.
